irq_pulse_gen: RTL and testbench
================================

Name: irq_pulse_gen

Overview:
- Programmable, multi-channel interrupt stimulus generator that drives the CPU's external hardware-interrupt inputs (HWInt) in P7 system simulation and on-board tests.
- Replaces hard-coded testbench interrupt waveforms with register-programmed low/high phases, pulse counts and a level-hold-until-ack mode.
- Sits behind the system bridge as a memory-mapped device.

Parameters:
- NUM_CH, 6, number of independent interrupt channels (1..16).
- CNT_W, 32, width of the PERIOD, WIDTH and COUNT registers and their counters.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- addr  input  8  byte address. addr[7:4] selects the channel, addr[3:2] selects the register, addr[1:0] is ignored.
- we  input  1  write strobe, sampled at posedge clk.
- wdata  input  32  write data.
- rdata  output  32  combinational read data for addr.
- irq  output  NUM_CH  registered per-channel interrupt lines.
- irq_any  output  1  registered OR of irq.

Behaviour:
- Registers per channel (reg select): 0 CTRL, 1 PERIOD, 2 WIDTH, 3 COUNT.
- CTRL bits:
  - [0] en.
  - [1] mode: 0 = pulse, 1 = level-hold.
  - [2] ack: write-only, self-clearing, reads 0.
  - [5:4] state: read-only, 0 IDLE, 1 LOW, 2 HIGH, 3 HOLD.
- COUNT read returns the remaining-pulse counter, not the programmed value.
- Channel index >= NUM_CH: writes ignored, reads return 0.
- Reset: all registers, counters and states cleared. irq = 0, irq_any = 0, all channels IDLE.
- Per-channel FSM (IDLE, LOW, HIGH, HOLD):
  - IDLE -> LOW on a CTRL write where en goes 0->1. On this transition, load phase counter = max(PERIOD,1) and rem = COUNT.
  - LOW: decrement each cycle. When the counter is 1, go to HIGH and load max(WIDTH,1). LOW therefore lasts exactly max(PERIOD,1) cycles.
  - HIGH: decrement each cycle. When the counter is 1:
    - mode = 1 -> go to HOLD.
    - otherwise -> end-of-pulse.
  - HOLD: remain until a CTRL write with ack = 1, then end-of-pulse. An ack in any other state is ignored.
  - End-of-pulse:
    - rem == 0 (infinite): reload PERIOD, go to LOW.
    - rem == 1: rem = 0, clear en, go to IDLE.
    - otherwise: rem decrements, reload PERIOD, go to LOW.
- irq[i] = 1 exactly while state is HIGH or HOLD; it is a registered state decode.
- Timing: a CTRL enable write sampled at edge t makes irq rise at edge t + max(PERIOD,1) + 1.
- Writes to PERIOD or WIDTH while running take effect at the next reload. Writes to COUNT take effect only at the next enable.
- CTRL write with en = 0 in any state: go to IDLE next edge and drop irq the same edge. rem is not modified.
- CTRL write with en = 1 while already enabled: no restart. mode is updated and applies from the next HIGH exit.
- A CTRL write with en = 1 and ack = 1 in HOLD: the ack is processed, en stays 1.
- Simultaneous end-of-phase and disable write: the disable wins (IDLE).
- reset asserted mid-operation: everything returns to the reset state next edge, regardless of we.
- Channels are fully independent. No prioritisation is done here; CP0 masks and prioritises.

Test Plan:
- Reset: hold reset 3 cycles while writing CTRL = 1 -> irq = 0, all rdata reads 0, state = IDLE.
- Periodic pulses: ch0 PERIOD = 10, WIDTH = 5, COUNT = 0, CTRL = 1 -> irq[0] low 10 cycles, high 5, repeating. First rise 11 edges after the write. Verify 20 periods with no drift.
- Finite count: ch2 PERIOD = 3, WIDTH = 2, COUNT = 3 -> exactly 3 pulses, then CTRL reads en = 0, state = 0, and COUNT reads 0.
- Level-hold: ch1 mode = 1, PERIOD = 4, WIDTH = 1, COUNT = 2, CTRL = 0x3 -> irq[1] stays high (state = 3) for 50 cycles. Writing CTRL = 0x7 drops irq next edge, and a second hold follows 4 cycles later. A second ack finishes the channel (en = 0).
- Disable and degenerate values: write CTRL = 0 mid-HIGH on ch0 -> irq[0] is 0 next edge. PERIOD = 0, WIDTH = 0 -> behaves as 1/1 (alternating toggle).
- Concurrency and decode: ch0 (10/5) and ch5 (7/3) run together -> each matches its own model and irq_any = OR of the two. A write to channel 9 has no effect and reads 0.

Source files
------------

// File: rtl/irq_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : irq_pulse_gen
// Purpose  : Register-programmed, multi-channel interrupt stimulus generator.
//            Each channel produces low/high pulse trains (optionally a finite
//            number of them) or holds its line high until software acks.
// Ports    : clk, reset (sync, active-high)
//            addr[7:0]  - [7:4] channel, [3:2] register, [1:0] ignored
//            we, wdata  - register write port, sampled at posedge clk
//            rdata      - combinational read data for addr
//            irq        - registered per-channel interrupt lines
//            irq_any    - registered OR of irq
// Registers: 0 CTRL {state[5:4], ack[2] (wo), mode[1], en[0]}
//            1 PERIOD, 2 WIDTH, 3 COUNT (reads remaining pulses)
// Revision : 1.0 - initial release
// ============================================================================
module irq_pulse_gen #(
    parameter int NUM_CH = 6,   // 1..16
    parameter int CNT_W  = 32   // 1..32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        addr,
    input  logic              we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [NUM_CH-1:0] irq,
    output logic              irq_any
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_low  = 2'd1;
    localparam logic [1:0] c_st_high = 2'd2;
    localparam logic [1:0] c_st_hold = 2'd3;

    localparam logic [1:0] c_reg_ctrl   = 2'd0;
    localparam logic [1:0] c_reg_period = 2'd1;
    localparam logic [1:0] c_reg_width  = 2'd2;
    localparam logic [1:0] c_reg_count  = 2'd3;

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [3:0]        w_ch;
    logic [1:0]        w_reg;
    logic [NUM_CH-1:0] w_irq_nxt;
    logic [31:0]       w_rd [NUM_CH];
    logic              w_unused;

    assign w_ch     = addr[7:4];
    assign w_reg    = addr[3:2];
    assign w_unused = ^{addr[1:0], wdata};

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [1:0]       r_state;
            logic [1:0]       w_state_nxt;
            logic             r_mode;
            logic [CNT_W-1:0] r_period;
            logic [CNT_W-1:0] r_width;
            logic [CNT_W-1:0] r_count;
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] r_rem;
            logic [CNT_W-1:0] w_cnt_nxt;
            logic [CNT_W-1:0] w_rem_nxt;
            logic [CNT_W-1:0] w_period1;
            logic [CNT_W-1:0] w_width1;
            logic             w_sel;
            logic             w_wr_ctrl;
            logic             w_dis;
            logic             w_ack;
            logic             w_eop;
            logic             w_irq_d;
            logic [31:0]      w_rd_ch;

            assign w_sel     = we && (w_ch == 4'(gi));
            assign w_wr_ctrl = w_sel && (w_reg == c_reg_ctrl);
            assign w_dis     = w_wr_ctrl && !wdata[0];
            assign w_ack     = w_wr_ctrl && wdata[2];

            // Zero phase lengths behave as one cycle so a channel never stalls.
            assign w_period1 = (r_period == '0) ? c_one : r_period;
            assign w_width1  = (r_width  == '0) ? c_one : r_width;

            // State register plus the programming registers.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state  <= c_st_idle;
                    r_mode   <= 1'b0;
                    r_period <= '0;
                    r_width  <= '0;
                    r_count  <= '0;
                    r_cnt    <= '0;
                    r_rem    <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                    r_rem   <= w_rem_nxt;
                    if (w_wr_ctrl) begin
                        r_mode <= wdata[1];
                    end
                    if (w_sel && (w_reg == c_reg_period)) begin
                        r_period <= CNT_W'(wdata);
                    end
                    if (w_sel && (w_reg == c_reg_width)) begin
                        r_width <= CNT_W'(wdata);
                    end
                    if (w_sel && (w_reg == c_reg_count)) begin
                        r_count <= CNT_W'(wdata);
                    end
                end
            end

            // Next-state and phase/pulse counter logic.
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                w_rem_nxt   = r_rem;
                w_eop       = 1'b0;
                case (r_state)
                    c_st_idle: begin
                        if (w_wr_ctrl && wdata[0]) begin
                            w_state_nxt = c_st_low;
                            w_cnt_nxt   = w_period1;
                            w_rem_nxt   = r_count;
                        end
                    end
                    c_st_low: begin
                        if (r_cnt == c_one) begin
                            w_state_nxt = c_st_high;
                            w_cnt_nxt   = w_width1;
                        end else begin
                            w_cnt_nxt = r_cnt - c_one;
                        end
                    end
                    c_st_high: begin
                        if (r_cnt == c_one) begin
                            if (r_mode) begin
                                w_state_nxt = c_st_hold;
                            end else begin
                                w_eop = 1'b1;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt - c_one;
                        end
                    end
                    c_st_hold: begin
                        if (w_ack) begin
                            w_eop = 1'b1;
                        end
                    end
                    default: w_state_nxt = c_st_idle;
                endcase

                // rem == 0 means "run forever"; rem == 1 is the last pulse.
                if (w_eop) begin
                    if (r_rem == c_one) begin
                        w_rem_nxt   = '0;
                        w_state_nxt = c_st_idle;
                    end else begin
                        if (r_rem != '0) begin
                            w_rem_nxt = r_rem - c_one;
                        end
                        w_state_nxt = c_st_low;
                        w_cnt_nxt   = w_period1;
                    end
                end

                // A disable write overrides any phase transition on the same edge.
                if (w_dis) begin
                    w_state_nxt = c_st_idle;
                end
            end

            // Line decode from the current state; a disable clears it at once
            // so irq falls on the same edge the channel returns to IDLE.
            always_comb begin
                w_irq_d = (r_state == c_st_high) || (r_state == c_st_hold);
                if (w_dis) begin
                    w_irq_d = 1'b0;
                end
            end

            assign w_irq_nxt[gi] = w_irq_d;

            always_comb begin
                case (w_reg)
                    c_reg_ctrl:   w_rd_ch = {26'd0, r_state, 2'b00, r_mode,
                                             (r_state != c_st_idle)};
                    c_reg_period: w_rd_ch = 32'(r_period);
                    c_reg_width:  w_rd_ch = 32'(r_width);
                    default:      w_rd_ch = 32'(r_rem);
                endcase
            end

            assign w_rd[gi] = w_rd_ch;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            irq     <= '0;
            irq_any <= 1'b0;
        end else begin
            irq     <= w_irq_nxt;
            irq_any <= |w_irq_nxt;
        end
    end

    // Unimplemented channel indices fall through to zero.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_ch == 4'(k)) begin
                rdata = w_rd[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_pulse_gen
// Purpose  : Self-checking bench for irq_pulse_gen. Expected irq lines are
//            derived from enable/ack/disable edge timestamps with plain
//            arithmetic (pulse position = elapsed edges mod period).
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_pulse_gen;

    localparam int NUM_CH = 6;
    localparam int INF    = 32'h7fff_ffff;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        addr;
    logic              we;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic [NUM_CH-1:0] irq;
    logic              irq_any;

    irq_pulse_gen #(.NUM_CH(NUM_CH), .CNT_W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq     (irq),
        .irq_any (irq_any)
    );

    always #5 clk = ~clk;

    int cyc = 0;                      // index of the most recent posedge
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    // Per-channel reference: timestamps and programmed values.
    bit m_act  [NUM_CH];
    bit m_mode [NUM_CH];
    int m_t0   [NUM_CH];   // enable edge
    int m_p    [NUM_CH];
    int m_w    [NUM_CH];
    int m_n    [NUM_CH];
    int m_dis  [NUM_CH];   // disable edge
    int m_ra   [NUM_CH];   // hold mode: previous high interval [ra, fa)
    int m_fa   [NUM_CH];
    int m_rb   [NUM_CH];   // hold mode: current high interval [rb, fb)
    int m_fb   [NUM_CH];
    int m_hrem [NUM_CH];

    logic [NUM_CH-1:0] exp_v;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pulse-mode state after edge e: 0 idle, 1 low, 2 high.
    function automatic int pstate(input int c, input int e);
        int k, per, n, pos;
        if (!m_act[c] || e < m_t0[c] || e >= m_dis[c]) return 0;
        k   = e - m_t0[c];
        per = m_p[c] + m_w[c];
        n   = k / per;
        pos = k % per;
        if (m_n[c] != 0 && n >= m_n[c]) return 0;
        return (pos < m_p[c]) ? 1 : 2;
    endfunction

    // irq after edge e: the line follows the state one edge later.
    function automatic bit exp_irq(input int c, input int e);
        if (!m_act[c] || e >= m_dis[c]) return 1'b0;
        if (m_mode[c])
            return (e >= m_ra[c] && e < m_fa[c]) || (e >= m_rb[c] && e < m_fb[c]);
        return pstate(c, e - 1) == 2;
    endfunction

    function automatic logic [7:0] ra(input int c, input int r);
        return 8'((c << 4) | (r << 2));
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            for (int c = 0; c < NUM_CH; c++) exp_v[c] = exp_irq(c, cyc);
            chk("irq", 32'(irq), 32'(exp_v));
            chk("irq_any", 32'(irq_any), 32'(|exp_v));
        end
    end

    // Called at the negedge phase; returns just after the sampling posedge.
    task automatic wr_edge(input logic [7:0] a, input logic [31:0] d, output int w);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        w     = cyc + 1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        int w;
        wr_edge(a, d, w);
        @(negedge clk);
    endtask

    task automatic chk_rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_ch(input int c, input bit mode, input int p, input int wd,
                            input int n, output int w);
        wr(ra(c, 1), 32'(p));
        wr(ra(c, 2), 32'(wd));
        wr(ra(c, 3), 32'(n));
        wr_edge(ra(c, 0), {30'd0, mode, 1'b1}, w);
        m_act[c]  = 1'b1;
        m_mode[c] = mode;
        m_t0[c]   = w;
        m_p[c]    = (p == 0) ? 1 : p;
        m_w[c]    = (wd == 0) ? 1 : wd;
        m_n[c]    = n;
        m_dis[c]  = INF;
        m_ra[c]   = 0;
        m_fa[c]   = 0;
        m_rb[c]   = w + m_p[c] + 1;
        m_fb[c]   = INF;
        m_hrem[c] = n;
        @(negedge clk);
    endtask

    task automatic stop_ch(input int c);
        int w;
        wr_edge(ra(c, 0), 32'd0, w);
        if (w < m_dis[c]) m_dis[c] = w;
        @(negedge clk);
    endtask

    // Ack write (CTRL = 0x7); the model reacts only if the channel is holding.
    task automatic ack_ch(input int c, input bit holding);
        int w;
        wr_edge(ra(c, 0), 32'h7, w);
        if (holding) begin
            m_ra[c] = m_rb[c];
            m_fa[c] = w + 1;
            if (m_hrem[c] == 1) begin
                m_rb[c] = INF;
            end else begin
                if (m_hrem[c] != 0) m_hrem[c]--;
                m_rb[c] = w + m_p[c] + 1;
            end
            m_fb[c] = INF;
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, wx, p3, w3, n3, p4, w4, n4, g;

        for (int c = 0; c < NUM_CH; c++) begin
            m_act[c] = 1'b0; m_mode[c] = 1'b0; m_t0[c] = 0; m_p[c] = 1; m_w[c] = 1;
            m_n[c] = 0; m_dis[c] = INF; m_ra[c] = 0; m_fa[c] = 0; m_rb[c] = INF;
            m_fb[c] = INF; m_hrem[c] = 0;
        end

        // Reset held while a CTRL enable is being written.
        reset = 1'b1; we = 1'b1; addr = 8'h00; wdata = 32'h1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; we = 1'b0;
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_irq_any", 32'(irq_any), 32'd0);
        for (int c = 0; c < NUM_CH; c++)
            for (int r = 0; r < 4; r++)
                chk_rd($sformatf("rst_rd_c%0d_r%0d", c, r), ra(c, r), 32'd0);
        chk_on = 1'b1;

        // Concurrent periodic channels: ch0 10/5, ch5 7/3, ch3 random.
        p3 = int'($urandom_range(0, 12));
        w3 = int'($urandom_range(0, 6));
        n3 = int'($urandom_range(0, 5));
        start_ch(0, 1'b0, 10, 5, 0, w0);
        start_ch(5, 1'b0, 7, 3, 0, wx);
        start_ch(3, 1'b0, p3, w3, n3, wx);
        g = 0;
        while (cyc < w0 + 10 && g < 40) begin @(negedge clk); g++; end
        chk("first_rise_pre", 32'(irq[0]), 32'd0);
        @(negedge clk);
        chk("first_rise", 32'(irq[0]), 32'd1);
        idle(300);
        chk_rd("ch0_ctrl_run", ra(0, 0), 32'(1 | (pstate(0, cyc) << 4)));
        chk_rd("ch0_period", ra(0, 1), 32'd10);
        chk_rd("ch0_width", ra(0, 2), 32'd5);
        chk_rd("ch5_count_inf", ra(5, 3), 32'd0);

        // Disable ch0 while its state is HIGH.
        g = 0;
        while (pstate(0, cyc) != 2 && g < 40) begin @(negedge clk); g++; end
        chk("wait_high", 32'(pstate(0, cyc)), 32'd2);
        stop_ch(0);
        chk("dis_irq0", 32'(irq[0]), 32'd0);
        chk_rd("dis_ctrl0", ra(0, 0), 32'd0);
        stop_ch(5);
        stop_ch(3);
        idle(5);

        // Finite pulse counts.
        p4 = int'($urandom_range(0, 6));
        w4 = int'($urandom_range(0, 4));
        n4 = int'($urandom_range(1, 4));
        start_ch(2, 1'b0, 3, 2, 3, wx);
        chk_rd("ch2_count_loaded", ra(2, 3), 32'd3);
        start_ch(4, 1'b0, p4, w4, n4, wx);
        idle(60);
        chk_rd("ch2_ctrl_done", ra(2, 0), 32'd0);
        chk_rd("ch2_count_done", ra(2, 3), 32'd0);
        chk_rd("ch4_ctrl_done", ra(4, 0), 32'd0);
        chk_rd("ch4_count_done", ra(4, 3), 32'd0);

        // Level-hold on ch1.
        start_ch(1, 1'b1, 4, 1, 2, wx);
        idle(50);
        chk("hold_irq1", 32'(irq[1]), 32'd1);
        chk_rd("hold_ctrl1", ra(1, 0), 32'h33);
        ack_ch(1, 1'b1);
        ack_ch(1, 1'b0);             // lands in LOW: ignored
        idle(20);
        chk_rd("hold2_ctrl1", ra(1, 0), 32'h33);
        ack_ch(1, 1'b1);
        idle(5);
        chk_rd("hold_done_ctrl1", ra(1, 0), 32'h02);
        chk_rd("hold_done_count1", ra(1, 3), 32'd0);

        // Degenerate PERIOD = WIDTH = 0 toggles every edge.
        start_ch(0, 1'b0, 0, 0, 0, wx);
        idle(20);
        stop_ch(0);
        idle(3);

        // Unimplemented channel 9.
        wr(8'h90, 32'h1);
        wr(8'h94, 32'h3);
        chk_rd("ch9_ctrl", 8'h90, 32'd0);
        chk_rd("ch9_period", 8'h94, 32'd0);
        idle(20);

        // Reset in the middle of a running channel, with a write pending.
        start_ch(5, 1'b0, 7, 3, 0, wx);
        idle(30);
        chk_on = 1'b0;
        reset = 1'b1; we = 1'b1; addr = ra(5, 0); wdata = 32'h1;
        @(posedge clk);
        #1;
        reset = 1'b0; we = 1'b0;
        for (int c = 0; c < NUM_CH; c++) m_act[c] = 1'b0;
        @(negedge clk);
        chk_on = 1'b1;
        chk("mid_rst_irq", 32'(irq), 32'd0);
        chk_rd("mid_rst_ctrl5", ra(5, 0), 32'd0);
        chk_rd("mid_rst_period5", ra(5, 1), 32'd0);
        idle(20);

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
